// File: rtl/time_of_day_counter_if.sv
// Bus bundle for time_of_day_counter: control inputs, time outputs, strobes.
// master drives EN/LOAD*/ALARM*; slave (the counter) drives time and strobes.
interface time_of_day_counter_if;
    logic       EN;
    logic       LOAD;
    logic [4:0] LOAD_HOUR;
    logic [5:0] LOAD_MIN;
    logic [5:0] LOAD_SEC;
    logic       ALARM_EN;
    logic [4:0] ALARM_HOUR;
    logic [5:0] ALARM_MIN;
    logic [5:0] SECOND;
    logic [5:0] MINUTE;
    logic [4:0] HOUR;
    logic       PM;
    logic       SEC_TICK;
    logic       MIN_TICK;
    logic       HOUR_TICK;
    logic       DAY_TICK;
    logic       ALARM;
    logic       LOAD_ERR;

    modport master (
        output EN, LOAD, LOAD_HOUR, LOAD_MIN, LOAD_SEC,
        output ALARM_EN, ALARM_HOUR, ALARM_MIN,
        input  SECOND, MINUTE, HOUR, PM,
        input  SEC_TICK, MIN_TICK, HOUR_TICK, DAY_TICK, ALARM, LOAD_ERR
    );

    modport slave (
        input  EN, LOAD, LOAD_HOUR, LOAD_MIN, LOAD_SEC,
        input  ALARM_EN, ALARM_HOUR, ALARM_MIN,
        output SECOND, MINUTE, HOUR, PM,
        output SEC_TICK, MIN_TICK, HOUR_TICK, DAY_TICK, ALARM, LOAD_ERR
    );
endinterface

// File: rtl/time_of_day_counter.sv
// Single-clock hh:mm:ss counter with prescaler, 12/24h display, load, alarm.
// Ports: CLK, RST (async high), bus (slave modport of time_of_day_counter_if).
module time_of_day_counter #(
    parameter int CLK_DIV  = 1,
    parameter bit MODE_12H = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    time_of_day_counter_if.slave   bus
);

    logic [5:0] sec, min;
    logic [4:0] h24;
    logic [5:0] nxt_sec, nxt_min;
    logic [4:0] nxt_h24;
    logic       sec_wrap, min_wrap, hour_wrap;
    logic       tick;
    logic       fields_ok, load_ok;
    logic       sec_tick, min_tick, hour_tick, day_tick;
    logic       alarm, load_err;

    assign fields_ok = (bus.LOAD_HOUR <= 5'd23) &&
                       (bus.LOAD_MIN  <= 6'd59) &&
                       (bus.LOAD_SEC  <= 6'd59);
    assign load_ok   = bus.LOAD && fields_ok;

    generate
        if (CLK_DIV == 1) begin : g_nopre
            assign tick = bus.EN;
        end else begin : g_pre
            localparam int PW = $clog2(CLK_DIV);
            localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
            logic [PW-1:0] pre;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    pre <= '0;
                end else if (load_ok) begin
                    pre <= '0;
                end else if (bus.EN) begin
                    pre <= (pre == LAST) ? '0 : pre + 1'b1;
                end
            end

            assign tick = bus.EN && (pre == LAST);
        end
    endgenerate

    // Next time on a tick; the alarm compares against this, not the
    // current time, so it fires on the edge where the match first appears.
    always_comb begin
        sec_wrap  = (sec == 6'd59);
        min_wrap  = sec_wrap && (min == 6'd59);
        hour_wrap = min_wrap && (h24 == 5'd23);
        nxt_sec   = sec_wrap ? 6'd0 : sec + 6'd1;
        nxt_min   = min;
        nxt_h24   = h24;
        if (sec_wrap) begin
            nxt_min = (min == 6'd59) ? 6'd0 : min + 6'd1;
        end
        if (min_wrap) begin
            nxt_h24 = (h24 == 5'd23) ? 5'd0 : h24 + 5'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sec       <= '0;
            min       <= '0;
            h24       <= '0;
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            alarm     <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            alarm     <= 1'b0;
            load_err  <= bus.LOAD && !fields_ok;
            if (load_ok) begin
                sec <= bus.LOAD_SEC;
                min <= bus.LOAD_MIN;
                h24 <= bus.LOAD_HOUR;
            end else if (tick) begin
                sec       <= nxt_sec;
                min       <= nxt_min;
                h24       <= nxt_h24;
                sec_tick  <= 1'b1;
                min_tick  <= sec_wrap;
                hour_tick <= min_wrap;
                day_tick  <= hour_wrap;
                // nxt_* are always in range, so bad alarm values never hit
                alarm     <= bus.ALARM_EN &&
                             (nxt_sec == 6'd0) &&
                             (nxt_min == bus.ALARM_MIN) &&
                             (nxt_h24 == bus.ALARM_HOUR);
            end
        end
    end

    logic [4:0] hour_disp;

    always_comb begin
        hour_disp = h24;
        if (MODE_12H) begin
            if (h24 == 5'd0) begin
                hour_disp = 5'd12;
            end else if (h24 > 5'd12) begin
                hour_disp = h24 - 5'd12;
            end
        end
    end

    assign bus.SECOND    = sec;
    assign bus.MINUTE    = min;
    assign bus.HOUR      = hour_disp;
    assign bus.PM        = (h24 >= 5'd12);
    assign bus.SEC_TICK  = sec_tick;
    assign bus.MIN_TICK  = min_tick;
    assign bus.HOUR_TICK = hour_tick;
    assign bus.DAY_TICK  = day_tick;
    assign bus.ALARM     = alarm;
    assign bus.LOAD_ERR  = load_err;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: three instances cover
// CLK_DIV=4/24h, CLK_DIV=1/24h and CLK_DIV=1/12h.
module tb_time_of_day_counter;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    time_of_day_counter_if b4 ();
    time_of_day_counter_if b1 ();
    time_of_day_counter_if bh ();

    time_of_day_counter #(.CLK_DIV(4), .MODE_12H(1'b0)) u_div4 (
        .CLK(CLK), .RST(RST), .bus(b4.slave)
    );
    time_of_day_counter #(.CLK_DIV(1), .MODE_12H(1'b0)) u_div1 (
        .CLK(CLK), .RST(RST), .bus(b1.slave)
    );
    time_of_day_counter #(.CLK_DIV(1), .MODE_12H(1'b1)) u_12h (
        .CLK(CLK), .RST(RST), .bus(bh.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({b4.SECOND, b4.MINUTE, b4.HOUR} !== 17'd0) begin
            bad++;
            $display("FAIL reset_time got=%0d:%0d:%0d want=0:0:0",
                     b4.HOUR, b4.MINUTE, b4.SECOND);
        end
        total++;
        if ({b4.SEC_TICK, b4.MIN_TICK, b4.HOUR_TICK, b4.DAY_TICK,
             b4.ALARM, b4.LOAD_ERR, b4.PM} !== 7'd0) begin
            bad++;
            $display("FAIL reset_strobes got nonzero want=0");
        end
        total++;
        if (bh.HOUR !== 5'd12 || bh.PM !== 1'b0) begin
            bad++;
            $display("FAIL reset_12h got=%0d pm=%0b want=12 pm=0",
                     bh.HOUR, bh.PM);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic test_prescaler();
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (b4.SEC_TICK !== (k % 4 == 0) ||
                b4.SECOND !== 6'(k / 4)) begin
                bad++;
                $display("FAIL prescale k=%0d got tick=%0b sec=%0d want tick=%0b sec=%0d",
                         k, b4.SEC_TICK, b4.SECOND, (k % 4 == 0), k / 4);
            end
        end
    endtask

    task automatic test_enable();
        step();
        step();
        b4.EN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (b4.SEC_TICK !== 1'b0 || b4.SECOND !== 6'd3) begin
                bad++;
                $display("FAIL freeze k=%0d got tick=%0b sec=%0d want tick=0 sec=3",
                         k, b4.SEC_TICK, b4.SECOND);
            end
        end
        b4.EN = 1'b1;
        step();
        total++;
        if (b4.SEC_TICK !== 1'b0 || b4.SECOND !== 6'd3) begin
            bad++;
            $display("FAIL resume1 got tick=%0b sec=%0d want tick=0 sec=3",
                     b4.SEC_TICK, b4.SECOND);
        end
        step();
        total++;
        if (b4.SEC_TICK !== 1'b1 || b4.SECOND !== 6'd4) begin
            bad++;
            $display("FAIL resume2 got tick=%0b sec=%0d want tick=1 sec=4",
                     b4.SEC_TICK, b4.SECOND);
        end
    endtask

    task automatic test_day_wrap();
        b1.LOAD = 1'b1;
        b1.LOAD_HOUR = 5'd23; b1.LOAD_MIN = 6'd59; b1.LOAD_SEC = 6'd58;
        step();
        b1.LOAD = 1'b0;
        total++;
        if ({b1.HOUR, b1.MINUTE, b1.SECOND} !== {5'd23, 6'd59, 6'd58} ||
            b1.SEC_TICK !== 1'b0) begin
            bad++;
            $display("FAIL load_2359 got=%0d:%0d:%0d tick=%0b want=23:59:58 tick=0",
                     b1.HOUR, b1.MINUTE, b1.SECOND, b1.SEC_TICK);
        end
        step();
        total++;
        if ({b1.HOUR, b1.MINUTE, b1.SECOND} !== {5'd23, 6'd59, 6'd59} ||
            {b1.SEC_TICK, b1.MIN_TICK, b1.HOUR_TICK, b1.DAY_TICK} !== 4'b1000) begin
            bad++;
            $display("FAIL tick_2359 got=%0d:%0d:%0d strobes=%b want=23:59:59 strobes=1000",
                     b1.HOUR, b1.MINUTE, b1.SECOND,
                     {b1.SEC_TICK, b1.MIN_TICK, b1.HOUR_TICK, b1.DAY_TICK});
        end
        step();
        total++;
        if ({b1.HOUR, b1.MINUTE, b1.SECOND} !== 17'd0 ||
            {b1.SEC_TICK, b1.MIN_TICK, b1.HOUR_TICK, b1.DAY_TICK} !== 4'b1111) begin
            bad++;
            $display("FAIL day_wrap got=%0d:%0d:%0d strobes=%b want=0:0:0 strobes=1111",
                     b1.HOUR, b1.MINUTE, b1.SECOND,
                     {b1.SEC_TICK, b1.MIN_TICK, b1.HOUR_TICK, b1.DAY_TICK});
        end
        step();
        total++;
        if (b1.SECOND !== 6'd1 ||
            {b1.SEC_TICK, b1.MIN_TICK, b1.HOUR_TICK, b1.DAY_TICK} !== 4'b1000) begin
            bad++;
            $display("FAIL after_wrap got sec=%0d strobes=%b want sec=1 strobes=1000",
                     b1.SECOND,
                     {b1.SEC_TICK, b1.MIN_TICK, b1.HOUR_TICK, b1.DAY_TICK});
        end
    endtask

    task automatic test_load();
        // every cycle is a tick at CLK_DIV=1: load must win
        b1.LOAD = 1'b1;
        b1.LOAD_HOUR = 5'd5; b1.LOAD_MIN = 6'd6; b1.LOAD_SEC = 6'd7;
        step();
        b1.LOAD = 1'b0;
        total++;
        if ({b1.HOUR, b1.MINUTE, b1.SECOND} !== {5'd5, 6'd6, 6'd7} ||
            b1.SEC_TICK !== 1'b0) begin
            bad++;
            $display("FAIL load_on_tick got=%0d:%0d:%0d tick=%0b want=5:6:7 tick=0",
                     b1.HOUR, b1.MINUTE, b1.SECOND, b1.SEC_TICK);
        end
        b1.EN = 1'b0;
        b1.LOAD = 1'b1;
        b1.LOAD_HOUR = 5'd24; b1.LOAD_MIN = 6'd0; b1.LOAD_SEC = 6'd0;
        step();
        b1.LOAD = 1'b0;
        total++;
        if ({b1.HOUR, b1.MINUTE, b1.SECOND} !== {5'd5, 6'd6, 6'd7} ||
            b1.LOAD_ERR !== 1'b1) begin
            bad++;
            $display("FAIL bad_hour got=%0d:%0d:%0d err=%0b want=5:6:7 err=1",
                     b1.HOUR, b1.MINUTE, b1.SECOND, b1.LOAD_ERR);
        end
        step();
        total++;
        if (b1.LOAD_ERR !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse got=%0b want=0", b1.LOAD_ERR);
        end
        // invalid load alongside a tick: tick still advances time
        b1.EN = 1'b1;
        b1.LOAD = 1'b1;
        b1.LOAD_HOUR = 5'd1; b1.LOAD_MIN = 6'd60; b1.LOAD_SEC = 6'd0;
        step();
        b1.LOAD = 1'b0;
        total++;
        if ({b1.HOUR, b1.MINUTE, b1.SECOND} !== {5'd5, 6'd6, 6'd8} ||
            b1.LOAD_ERR !== 1'b1 || b1.SEC_TICK !== 1'b1) begin
            bad++;
            $display("FAIL bad_min got=%0d:%0d:%0d err=%0b tick=%0b want=5:6:8 err=1 tick=1",
                     b1.HOUR, b1.MINUTE, b1.SECOND, b1.LOAD_ERR, b1.SEC_TICK);
        end
    endtask

    task automatic test_12h();
        bh.LOAD = 1'b1;
        bh.LOAD_HOUR = 5'd11; bh.LOAD_MIN = 6'd59; bh.LOAD_SEC = 6'd59;
        step();
        bh.LOAD = 1'b0;
        total++;
        if (bh.HOUR !== 5'd11 || bh.PM !== 1'b0) begin
            bad++;
            $display("FAIL h12_11 got=%0d pm=%0b want=11 pm=0", bh.HOUR, bh.PM);
        end
        step();
        total++;
        if (bh.HOUR !== 5'd12 || bh.PM !== 1'b1 || bh.MINUTE !== 6'd0) begin
            bad++;
            $display("FAIL h12_noon got=%0d pm=%0b min=%0d want=12 pm=1 min=0",
                     bh.HOUR, bh.PM, bh.MINUTE);
        end
        bh.LOAD = 1'b1;
        bh.LOAD_HOUR = 5'd0; bh.LOAD_MIN = 6'd0; bh.LOAD_SEC = 6'd0;
        step();
        total++;
        if (bh.HOUR !== 5'd12 || bh.PM !== 1'b0) begin
            bad++;
            $display("FAIL h12_midnight got=%0d pm=%0b want=12 pm=0", bh.HOUR, bh.PM);
        end
        bh.LOAD_HOUR = 5'd13;
        step();
        total++;
        if (bh.HOUR !== 5'd1 || bh.PM !== 1'b1) begin
            bad++;
            $display("FAIL h12_13 got=%0d pm=%0b want=1 pm=1", bh.HOUR, bh.PM);
        end
        bh.LOAD_HOUR = 5'd23;
        step();
        bh.LOAD = 1'b0;
        total++;
        if (bh.HOUR !== 5'd11 || bh.PM !== 1'b1) begin
            bad++;
            $display("FAIL h12_23 got=%0d pm=%0b want=11 pm=1", bh.HOUR, bh.PM);
        end
    endtask

    task automatic test_alarm();
        b1.ALARM_EN = 1'b1;
        b1.ALARM_HOUR = 5'd7; b1.ALARM_MIN = 6'd30;
        b1.LOAD = 1'b1;
        b1.LOAD_HOUR = 5'd7; b1.LOAD_MIN = 6'd29; b1.LOAD_SEC = 6'd59;
        step();
        b1.LOAD = 1'b0;
        total++;
        if (b1.ALARM !== 1'b0) begin
            bad++;
            $display("FAIL alarm_pre got=%0b want=0", b1.ALARM);
        end
        step();
        total++;
        if (b1.ALARM !== 1'b1 ||
            {b1.HOUR, b1.MINUTE, b1.SECOND} !== {5'd7, 6'd30, 6'd0}) begin
            bad++;
            $display("FAIL alarm_hit got=%0b at %0d:%0d:%0d want=1 at 7:30:0",
                     b1.ALARM, b1.HOUR, b1.MINUTE, b1.SECOND);
        end
        step();
        total++;
        if (b1.ALARM !== 1'b0) begin
            bad++;
            $display("FAIL alarm_one_cycle got=%0b want=0", b1.ALARM);
        end
        b1.LOAD = 1'b1;
        b1.LOAD_SEC = 6'd0; b1.LOAD_MIN = 6'd30;
        step();
        b1.LOAD = 1'b0;
        total++;
        if (b1.ALARM !== 1'b0 || b1.MINUTE !== 6'd30) begin
            bad++;
            $display("FAIL alarm_load got=%0b min=%0d want=0 min=30",
                     b1.ALARM, b1.MINUTE);
        end
        b1.ALARM_EN = 1'b0;
        b1.LOAD = 1'b1;
        b1.LOAD_SEC = 6'd59; b1.LOAD_MIN = 6'd29;
        step();
        b1.LOAD = 1'b0;
        step();
        total++;
        if (b1.ALARM !== 1'b0 || b1.MINUTE !== 6'd30) begin
            bad++;
            $display("FAIL alarm_disabled got=%0b min=%0d want=0 min=30",
                     b1.ALARM, b1.MINUTE);
        end
    endtask

    task automatic test_mid_reset();
        step();
        #1 RST = 1'b1;
        #1;
        total++;
        if (b4.SECOND !== 6'd0 || b1.SEC_TICK !== 1'b0 ||
            {b1.HOUR, b1.MINUTE, b1.SECOND} !== 17'd0) begin
            bad++;
            $display("FAIL mid_reset got sec4=%0d tick1=%0b t1=%0d:%0d:%0d want 0",
                     b4.SECOND, b1.SEC_TICK, b1.HOUR, b1.MINUTE, b1.SECOND);
        end
        total++;
        if (bh.HOUR !== 5'd12 || bh.PM !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_12h got=%0d pm=%0b want=12 pm=0",
                     bh.HOUR, bh.PM);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (b4.SEC_TICK !== (k == 4) || b4.SECOND !== 6'(k / 4)) begin
                bad++;
                $display("FAIL post_reset k=%0d got tick=%0b sec=%0d want tick=%0b sec=%0d",
                         k, b4.SEC_TICK, b4.SECOND, (k == 4), k / 4);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        b4.EN = 1'b1; b4.LOAD = 1'b0;
        b4.LOAD_HOUR = '0; b4.LOAD_MIN = '0; b4.LOAD_SEC = '0;
        b4.ALARM_EN = 1'b0; b4.ALARM_HOUR = '0; b4.ALARM_MIN = '0;
        b1.EN = 1'b1; b1.LOAD = 1'b0;
        b1.LOAD_HOUR = '0; b1.LOAD_MIN = '0; b1.LOAD_SEC = '0;
        b1.ALARM_EN = 1'b0; b1.ALARM_HOUR = '0; b1.ALARM_MIN = '0;
        bh.EN = 1'b1; bh.LOAD = 1'b0;
        bh.LOAD_HOUR = '0; bh.LOAD_MIN = '0; bh.LOAD_SEC = '0;
        bh.ALARM_EN = 1'b0; bh.ALARM_HOUR = '0; bh.ALARM_MIN = '0;
        test_reset();
        test_prescaler();
        test_enable();
        test_day_wrap();
        test_load();
        test_12h();
        test_alarm();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Parametrised, fully synchronous hh:mm:ss time-of-day counter. Replaces the ripple-clocked seconds/minutes/hours chain with a single-clock design.
- Adds a tick prescaler, a 12/24-hour display mode, validated time load, a run enable, a daily alarm, and one-cycle roll-over strobes for downstream display/alarm logic on the system bus.

Parameters:
- CLK_DIV, 1, CLK cycles per second tick (>=1). With 1, every enabled cycle is a tick.
- MODE_12H, 0, 0 = HOUR shown as 0..23; 1 = HOUR shown as 1..12 with PM flag.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run enable; low freezes prescaler and time.
- LOAD  in  1  one-cycle request to load LOAD_* (24-hour format).
- LOAD_HOUR  in  5  hour to load, 0..23.
- LOAD_MIN  in  6  minute to load, 0..59.
- LOAD_SEC  in  6  second to load, 0..59.
- ALARM_EN  in  1  alarm enable.
- ALARM_HOUR  in  5  alarm hour, 24-hour format.
- ALARM_MIN  in  6  alarm minute.
- SECOND  out  6  current second, 0..59.
- MINUTE  out  6  current minute, 0..59.
- HOUR  out  5  current hour, formatted per MODE_12H.
- PM  out  1  1 when internal hour >= 12 (valid in both modes).
- SEC_TICK  out  1  one-cycle strobe: second advanced.
- MIN_TICK  out  1  one-cycle strobe: second wrapped 59->0.
- HOUR_TICK  out  1  one-cycle strobe: minute wrapped 59->0.
- DAY_TICK  out  1  one-cycle strobe: 23:59:59 -> 00:00:00.
- ALARM  out  1  one-cycle strobe: tick reached ALARM_HOUR:ALARM_MIN:00.
- LOAD_ERR  out  1  one-cycle strobe: LOAD rejected (out-of-range field).

Behaviour:
- State: prescaler (ceil(log2(CLK_DIV)) bits; absent when CLK_DIV=1), sec[5:0], min[5:0], h24[4:0], plus registered strobes.
- Reset (async, RST=1): prescaler=0, time 00:00:00, all strobes 0. HOUR reads 0 (MODE_12H=0) or 12 (MODE_12H=1). PM=0.
- Tick condition: EN=1 and prescaler==CLK_DIV-1.
  - Otherwise, with EN=1, prescaler increments.
  - On a tick, prescaler returns to 0.
- On a tick edge:
  - sec increments.
  - sec 59 -> 0 carries into min; min 59 -> 0 carries into h24; h24 23 -> 0.
  - New time and all applicable strobes are registered on the same edge. Strobes are high exactly for the cycle in which the new value first appears.
  - A wrap at a higher level implies all lower strobes are also high (e.g. DAY_TICK implies HOUR_TICK, MIN_TICK and SEC_TICK).
- Latency: CLK_DIV enabled cycles from reset or load to the first SEC_TICK.
- EN=0: prescaler and time hold, no strobes. On re-enable, counting resumes from the held prescaler value.
- LOAD=1, fields valid (hour<=23, min<=59, sec<=59):
  - Time takes LOAD_* on the next edge and prescaler clears to 0.
  - No tick strobes or ALARM are generated for that edge.
  - LOAD has priority over a coincident tick; the tick is discarded.
  - LOAD works regardless of EN.
- LOAD=1, any field invalid: time and prescaler are unchanged (a coincident tick still proceeds normally), and LOAD_ERR pulses high for one cycle.
- ALARM: pulses on a tick edge whose new time equals ALARM_HOUR:ALARM_MIN:00 while ALARM_EN=1.
  - ALARM_EN and ALARM_* are sampled on that edge.
  - Never fires from a load.
  - Out-of-range alarm values never match.
- HOUR/PM are combinational decode of h24:
  - MODE_12H=0: HOUR=h24.
  - MODE_12H=1: HOUR = 12 if h24 is 0 or 12; h24 if 1..11; h24-12 if 13..23.
  - PM = (h24 >= 12).
- No derived clocks, and no outputs are driven from more than one process.

Test Plan:
- CLK_DIV=4, release RST, EN=1 -> SEC_TICK on cycles 4, 8, 12; SECOND = 1, 2, 3. Outputs 00:00:00 during reset.
- CLK_DIV=1, LOAD 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00. On the second tick SEC/MIN/HOUR/DAY_TICK all high for one cycle.
- LOAD 11:59:59, MODE_12H=1, 1 tick -> HOUR 12, PM 1, MINUTE 0. LOAD 00:00:00 -> HOUR 12, PM 0. LOAD 13:00:00 -> HOUR 1, PM 1.
- ALARM_EN=1, ALARM 07:30. LOAD 07:29:59, tick -> ALARM high for exactly one cycle at 07:30:00. LOAD 07:30:00 directly -> no ALARM. With ALARM_EN=0 -> no ALARM.
- LOAD 24:00:00 or LOAD_MIN=60 -> LOAD_ERR one cycle, time unchanged. LOAD asserted on a tick cycle with a valid value -> loaded value appears, no SEC_TICK.
- EN low for 10 cycles mid-count (CLK_DIV=4, prescaler at 2) -> time frozen. After re-enable, the next tick arrives 2 cycles later. RST asserted mid-count -> immediate 00:00:00, strobes 0.
